// File: rtl/ex_pipelined_shifter.sv
// Pipelined EX-stage barrel shifter (SLL/SRL/SRA) with PIPE_STAGES-cycle latency and valid/stall/flush control.
// Optional macro EX_SHIFTER_ROTATE_EN builds the rotate-right path for Op_In = 2'b11.
module ex_pipelined_shifter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Stall_EX,
    input  logic                     Flush_EX,
    input  logic                     Valid_In,
    input  logic [WIDTH-1:0]         Operand_In,
    input  logic [$clog2(WIDTH)-1:0] Shamt_In,
    input  logic [1:0]               Op_In,
    output logic [WIDTH-1:0]         Result_Out,
    output logic                     Bits_Lost_Out,
    output logic                     Valid_Out
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    // Barrel level l (shift by 2**l) is evaluated in stage stage_of(l).
    function automatic int stage_of(input int lvl);
        return (lvl * int'(PIPE_STAGES)) / int'(SHAMT_W);
    endfunction

    logic               in_valid [PIPE_STAGES];
    logic [WIDTH-1:0]   in_data  [PIPE_STAGES];
    logic [SHAMT_W-1:0] in_shamt [PIPE_STAGES];
    logic [1:0]         in_op    [PIPE_STAGES];
    logic               in_lost  [PIPE_STAGES];

    assign in_valid[0] = Valid_In;
    assign in_shamt[0] = Shamt_In;
    assign in_op[0]    = Op_In;
    assign in_lost[0]  = 1'b0;
`ifdef EX_SHIFTER_ROTATE_EN
    assign in_data[0]  = Operand_In;
`else
    // Without rotate support, op 11 produces zero regardless of the shift amount.
    assign in_data[0]  = (Op_In == OP_ROTR) ? '0 : Operand_In;
`endif

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] data_c;
        logic             lost_c;

        // Apply the barrel levels owned by this stage.
        always_comb begin
            data_c = in_data[s];
            lost_c = in_lost[s];
            for (int l = 0; l < int'(SHAMT_W); l++) begin
                if (stage_of(l) == s && in_shamt[s][l]) begin
                    case (in_op[s])
                        OP_SLL: begin
                            lost_c = lost_c | (|(data_c & ~({WIDTH{1'b1}} >> (1 << l))));
                            data_c = data_c << (1 << l);
                        end
                        OP_SRL: data_c = data_c >> (1 << l);
                        OP_SRA: data_c = WIDTH'($signed(data_c) >>> (1 << l));
`ifdef EX_SHIFTER_ROTATE_EN
                        OP_ROTR: data_c = (data_c >> (1 << l)) | (data_c << (WIDTH - (1 << l)));
`endif
                        default: ;
                    endcase
                end
            end
        end

        if (s < PIPE_STAGES - 1) begin : g_mid
            logic               valid_q;
            logic [WIDTH-1:0]   data_q;
            logic [SHAMT_W-1:0] shamt_q;
            logic [1:0]         op_q;
            logic               lost_q;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    shamt_q <= '0;
                    op_q    <= '0;
                    lost_q  <= 1'b0;
                end else if (Flush_EX) begin
                    valid_q <= 1'b0;
                end else if (!Stall_EX) begin
                    valid_q <= in_valid[s];
                    if (in_valid[s]) begin
                        data_q  <= data_c;
                        shamt_q <= in_shamt[s];
                        op_q    <= in_op[s];
                        lost_q  <= lost_c;
                    end
                end
            end

            assign in_valid[s+1] = valid_q;
            assign in_data[s+1]  = data_q;
            assign in_shamt[s+1] = shamt_q;
            assign in_op[s+1]    = op_q;
            assign in_lost[s+1]  = lost_q;
        end else begin : g_out
            // Final stage doubles as the output register; holds the last result when idle.
            always_ff @(posedge Clk) begin
                if (Reset || Flush_EX) begin
                    Valid_Out     <= 1'b0;
                    Result_Out    <= '0;
                    Bits_Lost_Out <= 1'b0;
                end else if (!Stall_EX) begin
                    Valid_Out <= in_valid[s];
                    if (in_valid[s]) begin
                        Result_Out    <= data_c;
                        Bits_Lost_Out <= lost_c;
                    end
                end
            end
        end
    end

endmodule
